// File: rtl/handshake_tx.sv
// handshake_tx: accepts words from a valid/ready upstream port and sends each
// one to an asynchronous remote side over a registered 4-phase req/ack
// handshake with bundled data. Each wait phase can be bounded by a timeout.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transfer; ready when the synchronized ack is low
// SETUP | word latched on o_data, one cycle of setup before req rises
// REQ   | o_req high, waiting for the synchronized ack to rise
// REL   | o_req low, waiting for the synchronized ack to fall
module handshake_tx #(
  parameter int DATA_W  = 8,
  parameter int N_DFF   = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_req,
  output logic [DATA_W-1:0] o_data,
  input  logic              ack_in,
  output logic              o_busy,
  output logic              o_timeout
);

  // A zero TIMEOUT still needs a legal one-bit counter; it is simply never compared.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    REL   = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [N_DFF-1:0]  sync;
  logic              ack_s;
  logic [CW-1:0]     wait_cnt;
  logic              accept;
  logic              to_last;
  logic              to_hit;

  assign ack_s   = sync[N_DFF-1];
  assign o_ready = (state == IDLE) && !ack_s;
  assign accept  = i_valid && o_ready;
  assign o_busy  = (state != IDLE);
  assign to_last = TO_EN && (wait_cnt == CNT_LAST);

  // Synchronize the asynchronous acknowledge; only ack_s is used downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[N_DFF-2:0], ack_in};
    end
  end

  // Next-state logic; a timeout is only taken when the exit condition is false.
  always_comb begin
    next_state = state;
    to_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = SETUP;
      end
      SETUP: begin
        next_state = REQ;
      end
      REQ: begin
        if (ack_s) begin
          next_state = REL;
        end else if (to_last) begin
          next_state = IDLE;
          to_hit     = 1'b1;
        end
      end
      REL: begin
        if (!ack_s) begin
          next_state = IDLE;
        end else if (to_last) begin
          next_state = IDLE;
          to_hit     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, registered req (decoded from next state so it tracks REQ exactly), data, counter, error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      o_req     <= 1'b0;
      o_data    <= '0;
      wait_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      state <= next_state;
      o_req <= (next_state == REQ);
      if (accept) o_data <= i_data;
      if (to_hit) o_timeout <= 1'b1;
      if ((next_state != state) && ((next_state == REQ) || (next_state == REL))) begin
        wait_cnt <= '0;
      end else if ((state == REQ) || (state == REL)) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule
